// File: rtl/ha_array_pkg.sv
// ha_array_pkg: shared defaults, b-vector offset and FSM state type for the ha_array accumulator
package ha_array_pkg;
  localparam int DEF_NUM_ROWS = 4;
  localparam int DEF_T_W = 9;
  localparam int DEF_B_W = 7;
  localparam int DEF_ROW_SHIFT = 2;
  localparam int DEF_P_W = 16;
  localparam int B_OFF = 2;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/ha_row_align.sv
// ha_row_align: weights one ha_array row, term = (t + (b << B_OFF)) << (ROW_SHIFT*row), P_W+1 bits
module ha_row_align
  import ha_array_pkg::*;
#(
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int T_W = DEF_T_W,
  parameter int B_W = DEF_B_W,
  parameter int ROW_SHIFT = DEF_ROW_SHIFT,
  parameter int P_W = DEF_P_W
) (
  input  logic [$clog2(NUM_ROWS)-1:0] row,
  input  logic [T_W-1:0]              t,
  input  logic [B_W-1:0]              b,
  output logic [P_W:0]                term
);
  logic [P_W:0] t_ext, b_ext;
  assign t_ext = (P_W + 1)'(t);
  assign b_ext = (P_W + 1)'(b);
  assign term = (t_ext + (b_ext << B_OFF)) << (ROW_SHIFT * row);
endmodule

// File: rtl/ha_array_accumulator.sv
// ha_array_accumulator: iteratively sums ha_array rows (one per cycle) into a product with overflow flag
module ha_array_accumulator
  import ha_array_pkg::*;
#(
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int T_W = DEF_T_W,
  parameter int B_W = DEF_B_W,
  parameter int ROW_SHIFT = DEF_ROW_SHIFT,
  parameter int P_W = DEF_P_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_ROWS*T_W-1:0] in_t,
  input  logic [NUM_ROWS*B_W-1:0] in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [P_W-1:0]          out_product,
  output logic                    out_overflow
);
  localparam int CW = $clog2(NUM_ROWS);
  state_t state, state_n;
  logic [NUM_ROWS*T_W-1:0] t_q;
  logic [NUM_ROWS*B_W-1:0] b_q;
  logic [P_W:0] acc, term;
  logic [CW-1:0] row_cnt;
  logic last;
  assign last = row_cnt == CW'(NUM_ROWS - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign out_product = acc[P_W-1:0];
  assign out_overflow = acc[P_W];
  ha_row_align #(
    .NUM_ROWS(NUM_ROWS), .T_W(T_W), .B_W(B_W), .ROW_SHIFT(ROW_SHIFT), .P_W(P_W)
  ) u_align (
    .row(row_cnt),
    .t(t_q[row_cnt*T_W +: T_W]),
    .b(b_q[row_cnt*B_W +: B_W]),
    .term(term)
  );
  always_comb begin
    state_n = state;
    if (state == IDLE && in_valid) state_n = ACCUM;
    else if (state == ACCUM && last) state_n = DONE;
    else if (state == DONE && out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      t_q <= '0;
      b_q <= '0;
      acc <= '0;
      row_cnt <= '0;
    end else begin
      state <= state_n;
      if (in_valid && in_ready) begin
        t_q <= in_t;
        b_q <= in_b;
        acc <= '0;
        row_cnt <= '0;
      end else if (state == ACCUM) begin
        acc <= acc + term;
        row_cnt <= row_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ha_array_accumulator.sv
// tb_ha_array_accumulator: directed self-checking bench for ha_array_accumulator
module tb_ha_array_accumulator;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_overflow;
  logic [35:0] in_t = '0;
  logic [27:0] in_b = '0;
  logic [15:0] out_product;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  ha_array_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_t(in_t), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_overflow(out_overflow)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic start(input logic [35:0] t, input logic [27:0] b);
    in_t = t;
    in_b = b;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    in_t = ~t;
    in_b = ~b;
  endtask
  task automatic finish_txn(input string tag, input logic [15:0] exp_p, input logic exp_ov);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_prod"}, out_product, exp_p);
    chk({tag, "_ovf"}, out_overflow, exp_ov);
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    chk({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
  endtask
  initial begin
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_prod", out_product, 0);
    chk("rst_ovf", out_overflow, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    start('0, '0);
    finish_txn("zero", 16'd0, 0);
    start(36'h1, '0);
    finish_txn("t0", 16'd1, 0);
    start({9'h100, 27'h0}, '0);
    finish_txn("t3", 16'd16384, 0);
    start('0, {7'h40, 21'h0});
    finish_txn("b3", 16'd16384, 0);
    start({9'h000, 9'h005, 9'h000, 9'h003}, {7'h00, 7'h00, 7'h01, 7'h00});
    finish_txn("mix", 16'd99, 0);
    start({9'h000, 9'h000, 9'h1FF, 9'h000}, '0);
    finish_txn("t1", 16'd2044, 0);
    start({4{9'h1FF}}, {4{7'h7F}});
    finish_txn("ones", 16'h5257, 1);
    start({9'h000, 9'h000, 9'h000, 9'h00A}, '0);
    repeat (4) @(posedge clk);
    #1;
    chk("stall_in", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("stall", {out_valid, in_ready, out_overflow, out_product}, {3'b100, 16'd10});
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    chk("stall_rel", {out_valid, in_ready}, 2'b01);
    start({4{9'h1FF}}, {4{7'h7F}});
    repeat (2) @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("mid_rst", {out_valid, in_ready, out_overflow, out_product}, {3'b010, 16'd0});
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_rst", {out_valid, in_ready}, 2'b01);
    start({9'h000, 9'h000, 9'h000, 9'h001}, {7'h00, 7'h00, 7'h00, 7'h01});
    finish_txn("after", 16'd5, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
